regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the single register-file write port between NUM_REQ writeback sources
//   (e.g. ALU and load unit).
//   - Each source has a 1-entry holding buffer with a valid/ready handshake.
//   - A round-robin arbiter drains the buffers into registered write-port signals.
//   - busy_mask exposes every destination register with a write still in flight,
//     for hazard detection.
// PARAMETERS
//   NUM_REQ  2   number of writeback requesters (2..4)
//   DATA_W   32  writeback data width
//   ADDR_W   5   significant register-index bits; rf_rd is zero-extended to 32
// PORTS
//   clk          in   1               clock, all state updates on rising edge
//   rst_n        in   1               asynchronous, active-low reset
//   req_valid    in   NUM_REQ         per-source write request valid
//   req_ready    out  NUM_REQ         per-source request accepted this cycle
//   req_rd       in   NUM_REQ*ADDR_W  per-source destination index, packed, src0 in LSBs
//   req_data     in   NUM_REQ*DATA_W  per-source write data, packed
//   rf_wr_en     out  1               to register file wr_en
//   rf_rd        out  32              to register file rd, bits [31:ADDR_W] = 0
//   rf_result    out  DATA_W          to register file result
//   busy_mask    out  32              bit r set = write to xr pending (buffer or output stage)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - All buffers empty; rr_ptr = 0.
//     - rf_wr_en = 0, rf_rd = 0, rf_result = 0, busy_mask = 0.
//     - req_ready is not asserted while rst_n = 0.
//   Handshake:
//     - Transfer on source i when req_valid[i] && req_ready[i] at a clock edge.
//     - req_ready[i] = !buf_v[i] || grant[i], where grant[i] means the buffer drains
//       this cycle. This gives full throughput of one transfer per source per cycle
//       when that source wins every arbitration.
//     - req_ready must not depend on req_valid.
//   Arbitration (combinational, each cycle):
//     - Candidates are the sources with buf_v set.
//     - Search starts at rr_ptr and wraps modulo NUM_REQ; the first candidate wins.
//     - At most one grant per cycle.
//     - After a grant to source g: rr_ptr <= (g+1) mod NUM_REQ.
//     - If there is no grant, rr_ptr holds.
//   Output stage:
//     - On a grant, at the next edge: rf_rd <= buf_rd[g], rf_result <= buf_data[g],
//       rf_wr_en <= (buf_rd[g] != 0).
//     - On no grant: rf_wr_en <= 0; rf_rd and rf_result hold their previous values.
//   Latency:
//     - Accept at edge E0; earliest grant in the cycle after E0.
//     - rf_wr_en high after E1; register file commits at E2.
//     - A losing source waits at most NUM_REQ-1 extra cycles.
//   x0 handling:
//     - A request with rd = 0 is accepted and granted normally, but rf_wr_en stays 0.
//     - It never sets busy_mask[0]; busy_mask[0] is always 0.
//   busy_mask:
//     - Combinational OR of (buf_v[i] ? onehot(buf_rd[i]) : 0) over all i,
//       plus onehot(rf_rd) when rf_wr_en = 1.
//     - The bit clears the cycle after the register file commits.
//   Ordering:
//     - Program order is preserved within a source.
//     - There is no ordering across sources. Upstream must not issue the same
//       nonzero rd from two sources while busy_mask[rd] is set.
//     - If this rule is violated, both writes still occur in arbitration order.
//       There is no error and no merge.
//   Simultaneous drain and accept on source i: the new entry overwrites the buffer
//   in the same edge; buf_v stays 1.
//   Reset mid-operation: all buffered and output-stage writes are dropped and no
//   partial write occurs; rf_wr_en falls asynchronously with rst_n.
// STRUCTURE
//   Package regfile_pkg:
//     - localparams REG_ADDR_W = 5, REG_DATA_W = 32, REG_ZERO = 5'd0
//     - function onehot32(addr) returning a 32-bit mask
//   Sub-module rr_arbiter #(N):
//     - Inputs: req[N], ptr[clog2 N]; output: grant[N] one-hot.
//     - Purely combinational; rr_ptr lives in the parent.
//   Top level holds the buffers, rr_ptr, output stage and busy_mask logic.
// TESTING
//   1 Src0 rd=5 data=0xDEADBEEF alone -> ready=1; rf_wr_en pulses 1 cycle after
//     accept with rf_rd=5, rf_result=0xDEADBEEF; busy_mask[5] set for 2 cycles.
//   2 Src0 rd=3 and src1 rd=7 both held valid for 4 cycles, rr_ptr=0 -> writes
//     alternate 3,7,3,7; each source's req_ready alternates.
//   3 Src1 rd=0 data=0x1234 -> accepted and granted; rf_wr_en stays 0;
//     busy_mask stays 0.
//   4 Src0 streams rd=1,2,3,4 back-to-back with src1 idle -> 4 consecutive
//     rf_wr_en cycles in order 1,2,3,4; req_ready[0] stays 1.
//   5 Both buffers full (rd=9, rd=10), assert rst_n=0 for 1 cycle -> rf_wr_en=0
//     immediately; busy_mask=0; no write to x9 or x10 after release.
//   6 Src0 and src1 both target rd=12 (violation) -> two writes in arbitration
//     order; final value is the later-granted data.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
// Also used by any hazard logic that decodes register indices.
package regfile_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam int                    REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

    // x0 is hardwired to zero, so it never appears in a busy mask.
    function automatic logic [31:0] onehot32(input logic [REG_ADDR_W-1:0] addr);
        onehot32 = (addr == REG_ZERO) ? 32'd0 : (32'd1 << addr);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares one register-file write port among NUM_REQ writeback sources.
// Each source has a one-entry buffer; buffers drain round-robin into a registered write stage.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_wr_en,
    output logic [31:0]               rf_rd,
    output logic [DATA_W-1:0]         rf_result,
    output logic [31:0]               busy_mask
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] buf_v;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] load;
    logic [ADDR_W-1:0]  buf_rd   [NUM_REQ];
    logic [DATA_W-1:0]  buf_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  out_rd;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (buf_v),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign gnt_any = |grant;

    // A draining buffer can take a new entry in the same cycle; ready is held low in reset.
    assign req_ready = rst_n ? (~buf_v | grant) : '0;
    assign load      = req_valid & req_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v  <= '0;
            rr_ptr <= '0;
        end else begin
            buf_v <= load | (buf_v & ~grant);
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
        end
    end

    // NOTE: buffer payload is not reset; it is only observed while its buf_v bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (load[i]) begin
                buf_rd[i]   <= req_rd[i*ADDR_W +: ADDR_W];
                buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en  <= 1'b0;
            out_rd    <= '0;
            rf_result <= '0;
        end else if (gnt_any) begin
            rf_wr_en  <= (buf_rd[gnt_idx] != '0);
            out_rd    <= buf_rd[gnt_idx];
            rf_result <= buf_data[gnt_idx];
        end else begin
            rf_wr_en  <= 1'b0;
        end
    end

    assign rf_rd = 32'(out_rd);

    always_comb begin
        busy_mask = rf_wr_en ? onehot32(REG_ADDR_W'(out_rd)) : 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (buf_v[i]) busy_mask = busy_mask | onehot32(REG_ADDR_W'(buf_rd[i]));
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus random stimulus for regfile_wr_arbiter, checked against a
// transaction-level model of the buffers, round-robin order and register file.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        rf_wr_en;
    logic [31:0] rf_rd;
    logic [31:0] rf_result;
    logic [31:0] busy_mask;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: pending entry per source, next source to favour, write stage, register file.
    bit          m_v    [2];
    logic [4:0]  m_rd   [2];
    logic [31:0] m_data [2];
    int          m_ptr;
    bit          m_wen;
    logic [4:0]  m_out_rd;
    logic [31:0] m_out_data;
    logic [31:0] rf_model [32] = '{default: 32'd0};

    // Register file as seen through the DUT write port.
    logic [31:0] tb_rf [32] = '{default: 32'd0};

    regfile_wr_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .rf_wr_en  (rf_wr_en),
        .rf_rd     (rf_rd),
        .rf_result (rf_result),
        .busy_mask (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) tb_rf[rf_rd[4:0]] <= rf_result;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_v[0]     = 1'b0;
        m_v[1]     = 1'b0;
        m_ptr      = 0;
        m_wen      = 1'b0;
        m_out_rd   = 5'd0;
        m_out_data = 32'd0;
    endtask

    // Called just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic [4:0] rd1, input logic [31:0] d1);
        int          w;
        logic [1:0]  er;
        logic [31:0] eb;
        req_valid = v;
        req_rd    = {rd1, rd0};
        req_data  = {d1, d0};
        #1;
        w = -1;
        for (int k = 0; k < 2; k++) begin
            if (w < 0 && m_v[(m_ptr + k) % 2]) w = (m_ptr + k) % 2;
        end
        eb = m_wen ? (32'd1 << m_out_rd) : 32'd0;
        for (int i = 0; i < 2; i++) begin
            er[i] = !m_v[i] || (w == i);
            if (m_v[i]) eb = eb | (32'd1 << m_rd[i]);
        end
        eb[0] = 1'b0;
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy_mask", busy_mask, eb);
        @(posedge clk);
        if (m_wen) rf_model[m_out_rd] = m_out_data;
        if (w >= 0) begin
            m_wen      = (m_rd[w] != 5'd0);
            m_out_rd   = m_rd[w];
            m_out_data = m_data[w];
            m_ptr      = (w + 1) % 2;
            m_v[w]     = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        if (v[0] && er[0]) begin m_v[0] = 1'b1; m_rd[0] = rd0; m_data[0] = d0; end
        if (v[1] && er[1]) begin m_v[1] = 1'b1; m_rd[1] = rd1; m_data[1] = d1; end
        #1;
        check("rf_wr_en", 32'(rf_wr_en), 32'(m_wen));
        check("rf_rd", rf_rd, 32'(m_out_rd));
        check("rf_result", rf_result, m_out_data);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    // Asserts reset mid-cycle, before the next rising edge.
    task automatic do_reset();
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_en_async", 32'(rf_wr_en), 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        check("rst_wr_en_held", 32'(rf_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_rd    = '0;
        req_data  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr_en", 32'(rf_wr_en), 32'd0);
        check("reset_rd", rf_rd, 32'd0);
        check("reset_result", rf_result, 32'd0);
        check("reset_busy", busy_mask, 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from source 0.
        cycle(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        idle(3);
        check("t1_x5", tb_rf[5], 32'hDEADBEEF);

        // Both sources held valid; pointer restarted at 0.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(2'b11, 5'd3, 32'hA000_0003 + i, 5'd7, 32'hB000_0007 + i);
        idle(3);

        // Write to x0 is consumed but never enables the port.
        cycle(2'b10, 5'd0, 32'd0, 5'd0, 32'h1234);
        idle(3);

        // Back-to-back stream from source 0.
        for (int i = 1; i <= 4; i++) cycle(2'b01, 5'(i), 32'h0000_1000 + i, 5'd0, 32'd0);
        idle(3);

        // Reset with both buffers occupied drops both writes.
        cycle(2'b11, 5'd9, 32'h9999_9999, 5'd10, 32'hAAAA_0010);
        do_reset();
        idle(3);
        check("t5_x9", tb_rf[9], rf_model[9]);
        check("t5_x10", tb_rf[10], rf_model[10]);

        // Same destination from both sources: both land, later grant wins.
        cycle(2'b11, 5'd12, 32'h0000_AAAA, 5'd12, 32'h0000_BBBB);
        idle(3);
        check("t6_x12", tb_rf[12], rf_model[12]);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), $urandom);
        end
        idle(4);
        for (int r = 0; r < 32; r++) check($sformatf("rf_x%0d", r), tb_rf[r], rf_model[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
